data_mem_responder: RTL

Memory-side responder for the mem_read / mem_write strobes that the CPU control path drives for load (opcode 01) and store (opcode 10).
- Owns the data memory array and inserts a configurable number of wait states per access.
- Holds the pipeline via stall until each access completes.
- Returns load data with a one-cycle valid pulse.
- Sits between the control unit / register file and on-chip storage in the 8-bit core.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_array.sv | 35 +++
 rtl/data_mem_responder.sv | 113 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the 8-bit core's memory path.
//   state_e : responder FSM states
//   op_e    : latched access type
//   MEM_ADDR_W / MEM_DATA_W : default widths, shared with the control unit
//                             and register file
package mem_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } op_e;

endpackage

// File: rtl/mem_array.sv
// Single-port storage, DATA_W x 2**ADDR_W, synchronous write and read.
//   clk, rst_n : clock, async active-low reset (read register only)
//   we_i       : write wdata_i to addr_i at the edge
//   re_i       : capture array[addr_i] into rdata_o at the edge
//   rdata_o    : last captured read word, 0 after reset
// The array itself is never reset; only the read register is, so the
// load result port starts from a known value.
module mem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU's mem_read / mem_write strobes.
// Latches one request, waits WAIT_CYCLES cycles, performs the access on the
// edge entering DONE, and reports completion with a one-cycle pulse.
//   clk, rst_n            : clock, async active-low reset
//   mem_read, mem_write   : request strobes, held by the CPU while stall=1
//   addr, wdata           : word address and store data
//   rdata, rdata_valid    : load result (held) and its completion pulse
//   write_ack             : store-committed pulse
//   stall                 : CPU must hold while high
//   err                   : pulse after both strobes were seen together
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              write_ack,
    output logic              stall,
    output logic              err
);

    localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

    state_e            state_q;
    op_e               op_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rdata_valid_q, write_ack_q, err_q;

    logic              req_valid, req_both, access;
    op_e               req_op, acc_op;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    assign req_valid = mem_read ^ mem_write;
    assign req_both  = mem_read & mem_write;
    assign req_op    = mem_write ? OP_STORE : OP_LOAD;

    // With zero wait states the access happens on the accepting edge, so it
    // must use the live inputs rather than the not-yet-latched copies.
    assign access = rst_n &&
                    (((state_q == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                     ((state_q == WAIT) && (cnt_q == 4'd1)));
    assign acc_op    = (state_q == IDLE) ? req_op : op_q;
    assign acc_addr  = (state_q == IDLE) ? addr   : addr_q;
    assign acc_wdata = (state_q == IDLE) ? wdata  : wdata_q;

    // Gated by rst_n so a request held during reset never shows as a stall.
    assign stall = rst_n && (((state_q == IDLE) && req_valid) || (state_q == WAIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            op_q          <= OP_LOAD;
            cnt_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            write_ack_q   <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            rdata_valid_q <= access && (acc_op == OP_LOAD);
            write_ack_q   <= access && (acc_op == OP_STORE);
            err_q         <= (state_q == IDLE) && req_both;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt_q   <= WAIT_C;
                        state_q <= (WAIT_CYCLES == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= DONE;
                end
                // CPU advances on this edge; a still-present request is stale.
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (access && (acc_op == OP_STORE)),
        .re_i    (access && (acc_op == OP_LOAD)),
        .addr_i  (acc_addr),
        .wdata_i (acc_wdata),
        .rdata_o (rdata)
    );

    assign rdata_valid = rdata_valid_q;
    assign write_ack   = write_ack_q;
    assign err         = err_q;

endmodule
